wrapper_top: RTL and testbench
==============================

Name:
wrapper_top

Overview:
- Program-loading glue for the sanitizer-dispenser RISC-V SoC: receives a program over UART (8N1), assembles little-endian 32-bit words and writes them into an on-block instruction memory.
- Holds the external core in reset until a terminator word arrives, then releases it.
- Registers the core's GPIO outputs onto output_gpio_pins and synchronises input_gpio_pins for the core.
- The core itself is external and connects through the imem_* and gpio_* ports.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BIT_RATE, 9600, UART baud; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division, 5208)
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2)
TERMINATOR, 32'hFFFFFFFF, word that ends loading (never written to memory)

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous, active-low reset
uart_rxd  in  1  UART receive line, idle high
uart_rx_en  in  1  receive enable; when 0 the receiver stays idle
uart_rx_break  out  1  one-cycle pulse: BREAK detected (data 0x00 and stop bit 0)
uart_rx_valid  out  1  one-cycle pulse: byte received with a valid stop bit
uart_rx_data  out  8  most recent received byte, held until the next byte completes
input_gpio_pins  in  2  external sensor inputs
output_gpio_pins  out  3  registered actuator outputs
write_done  out  1  sticky 1 once TERMINATOR has been received
core_rstn  out  1  active-low reset to the core; equals resetn AND write_done (registered)
imem_raddr  in  log2(IMEM_DEPTH)  core fetch word address
imem_rdata  out  32  fetch data, one-cycle read latency
gpio_in_sync  out  2  input_gpio_pins after a 2-flop synchroniser
gpio_out_req  in  3  core GPIO output bits (core register x30[4:2]); treated as 0 when unconnected

Behaviour:
- Reset (resetn = 0, asynchronous): all outputs 0, including uart_rx_data, write_done, core_rstn and output_gpio_pins; word address 0; byte counter 0; receiver in IDLE. Memory contents are not cleared.
- Input synchroniser: uart_rxd passes through a 2-flop synchroniser before the receiver uses it.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when the line is low and uart_rx_en = 1.
  - START: at the half-bit point, if the line is still low -> DATA; if high, treat as a glitch -> IDLE.
  - DATA: sample every CYCLES_PER_BIT cycles at mid-bit, 8 bits, LSB first.
  - STOP: sample mid-bit.
- Data update and handshake:
  - uart_rx_data is updated at the 8th data sample, so it is valid at least 20 us before the end of the stop bit.
  - At the stop sample: if the line is 1, pulse uart_rx_valid for one cycle; if it is 0 and the data is 0x00, pulse uart_rx_break; otherwise framing error, with no pulse and the byte discarded.
  - Return to IDLE after the stop sample.
- uart_rx_en deasserted mid-frame: abort to IDLE; no pulses are generated.
- Loader:
  - On each uart_rx_valid while write_done = 0, the byte goes into word lane byte_cnt (lane 0 = bits 7:0) and byte_cnt increments modulo 4.
  - On the 4th byte, the assembled word W is compared against TERMINATOR.
  - If W == TERMINATOR: set write_done = 1 and do not write memory.
  - Otherwise: write W to imem[waddr] and increment waddr.
- Write limit: once waddr reaches IMEM_DEPTH, further words are dropped (no wrap) until the terminator arrives.
- After write_done: all further bytes are ignored by the loader, but the UART outputs keep working. BREAK never affects the loader.
- write_done is sticky until resetn goes low. core_rstn rises one cycle after write_done.
- Fetch: imem_rdata = imem[imem_raddr], registered, one-cycle latency. The read port is usable at any time.
- GPIO outputs: output_gpio_pins register gpio_out_req each cycle only while write_done = 1; otherwise they hold 0.
- GPIO inputs: gpio_in_sync has 2 cycles of latency.

Decomposition:
- Shared package: CLK_HZ and BIT_RATE defaults, CYCLES_PER_BIT, the receiver state enum, and TERMINATOR.
- One natural sub-module, uart_rx_core, holding the synchroniser, receiver FSM and the rx_valid/break/data outputs.
- Loader, memory and GPIO logic stay in wrapper_top.

Test Plan:
- Hold resetn = 0 for 4 us -> all outputs 0 and core_rstn = 0. Release resetn, then send byte 0x13 at 9600 baud -> uart_rx_data = 0x13 within 1 us of the stop bit's start; uart_rx_valid pulses exactly once.
- Send words 0x00000000, 0x00000000, 0xfa010113 (little-endian bytes), then FF FF FF FF -> imem[0..2] hold those values; write_done = 1; core_rstn = 1 one cycle later. With imem_raddr = 2, imem_rdata = 0xfa010113 after 1 cycle.
- After write_done, send 0x04812e23 -> imem[3] unchanged, uart_rx_data still updates.
- Send a frame with 0x00 data and stop bit low -> uart_rx_break pulses, uart_rx_valid stays 0, and byte_cnt is unchanged.
- Before write_done, drive gpio_out_req = 3'b101 -> output_gpio_pins = 0. After write_done -> output_gpio_pins = 3'b101 one cycle later. With input_gpio_pins = 2'b10 -> gpio_in_sync = 2'b10 after 2 cycles.
- Assert resetn low mid-frame and mid-word -> FSM returns to IDLE, byte_cnt and waddr return to 0, and write_done is cleared.

Source files
------------

// File: rtl/wrapper_top_pkg.sv
// Shared constants and types for the program-loading glue and its UART receiver.
package wrapper_top_pkg;

  localparam int unsigned CLK_HZ_DEF     = 50_000_000;
  localparam int unsigned BIT_RATE_DEF   = 9600;
  localparam int unsigned CYCLES_PER_BIT = CLK_HZ_DEF / BIT_RATE_DEF;
  localparam logic [31:0] TERMINATOR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/wrapper_top_uart_rx_core.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// registered valid/break pulses and a held data byte.
module uart_rx_core
  import wrapper_top_pkg::*;
#(
  parameter int unsigned CPB = CYCLES_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  input  logic       en_i,
  output logic       valid_o,
  output logic       break_o,
  output logic [7:0] data_o
);

  localparam int unsigned CW        = $clog2(CPB);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CPB - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          break_q, break_d;
  logic [1:0]    sync_q;
  logic          rxd;

  assign rxd     = sync_q[1];
  assign valid_o = valid_q;
  assign break_o = break_q;
  assign data_o  = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    break_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxd) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            data_d  = {rxd, shift_q[7:1]};
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          state_d = RX_IDLE;
          if (rxd)                valid_d = 1'b1;
          else if (data_q == '0)  break_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Disable aborts any frame in flight and suppresses its pulses.
    if (!en_i) begin
      state_d = RX_IDLE;
      valid_d = 1'b0;
      break_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      break_q <= 1'b0;
      sync_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      break_q <= break_d;
      sync_q  <= {sync_q[0], rxd_i};
    end
  end

endmodule

// File: rtl/wrapper_top.sv
// Program loader: UART bytes -> little-endian words -> instruction memory,
// core reset release on terminator, GPIO registering and synchronisation.
module wrapper_top
  import wrapper_top_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned BIT_RATE   = BIT_RATE_DEF,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] TERMINATOR = TERMINATOR_DEF,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          uart_rxd,
  input  logic          uart_rx_en,
  output logic          uart_rx_break,
  output logic          uart_rx_valid,
  output logic [7:0]    uart_rx_data,
  input  logic [1:0]    input_gpio_pins,
  output logic [2:0]    output_gpio_pins,
  output logic          write_done,
  output logic          core_rstn,
  input  logic [AW-1:0] imem_raddr,
  output logic [31:0]   imem_rdata,
  output logic [1:0]    gpio_in_sync,
  input  logic [2:0]    gpio_out_req
);

  uart_rx_core #(
    .CPB(CLK_HZ / BIT_RATE)
  ) u_rx (
    .clk_i  (clk),
    .rst_ni (resetn),
    .rxd_i  (uart_rxd),
    .en_i   (uart_rx_en),
    .valid_o(uart_rx_valid),
    .break_o(uart_rx_break),
    .data_o (uart_rx_data)
  );

  // waddr carries one extra bit; its MSB marks the memory as full.
  logic [AW:0]   waddr_q, waddr_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   lanes_q, lanes_d;
  logic          done_q, done_d;
  logic          we;
  logic [31:0]   word;
  logic [31:0]   mem [IMEM_DEPTH];
  logic [31:0]   rdata_q;
  logic [2:0]    gpio_out_q;
  logic [1:0]    gin_s1_q, gin_s2_q;
  logic          core_rstn_q;

  always_comb begin
    waddr_d = waddr_q;
    bcnt_d  = bcnt_q;
    lanes_d = lanes_q;
    done_d  = done_q;
    we      = 1'b0;
    word    = {uart_rx_data, lanes_q};
    if (uart_rx_valid && !done_q) begin
      bcnt_d = bcnt_q + 2'd1;
      case (bcnt_q)
        2'd0: lanes_d[7:0]   = uart_rx_data;
        2'd1: lanes_d[15:8]  = uart_rx_data;
        2'd2: lanes_d[23:16] = uart_rx_data;
        default: begin
          if (word == TERMINATOR) begin
            done_d = 1'b1;
          end else if (!waddr_q[AW]) begin
            we      = 1'b1;
            waddr_d = waddr_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr_q[AW-1:0]] <= word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      waddr_q     <= '0;
      bcnt_q      <= '0;
      lanes_q     <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      gpio_out_q  <= '0;
      gin_s1_q    <= '0;
      gin_s2_q    <= '0;
      core_rstn_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      bcnt_q      <= bcnt_d;
      lanes_q     <= lanes_d;
      done_q      <= done_d;
      rdata_q     <= mem[imem_raddr];
      gpio_out_q  <= done_q ? gpio_out_req : '0;
      gin_s1_q    <= input_gpio_pins;
      gin_s2_q    <= gin_s1_q;
      core_rstn_q <= done_q;
    end
  end

  assign write_done       = done_q;
  assign core_rstn        = core_rstn_q;
  assign imem_rdata       = rdata_q;
  assign output_gpio_pins = gpio_out_q;
  assign gpio_in_sync     = gin_s2_q;

endmodule

// File: tb/tb_wrapper_top.sv
// Self-checking bench for wrapper_top: frame table, loader reference model, GPIO and reset sequences.
module tb_wrapper_top;

  localparam int unsigned CLK_HZ   = 320;
  localparam int unsigned BIT_RATE = 10;
  localparam int unsigned CPB      = CLK_HZ / BIT_RATE;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AW       = 3;
  localparam logic [31:0] TERM     = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          uart_rxd = 1'b1;
  logic          uart_rx_en = 1'b1;
  logic          uart_rx_break, uart_rx_valid;
  logic [7:0]    uart_rx_data;
  logic [1:0]    input_gpio_pins = 2'b11;
  logic [2:0]    output_gpio_pins;
  logic          write_done, core_rstn;
  logic [AW-1:0] imem_raddr = '0;
  logic [31:0]   imem_rdata;
  logic [1:0]    gpio_in_sync;
  logic [2:0]    gpio_out_req = 3'b101;

  wrapper_top #(
    .CLK_HZ    (CLK_HZ),
    .BIT_RATE  (BIT_RATE),
    .IMEM_DEPTH(DEPTH),
    .TERMINATOR(TERM)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .uart_rxd        (uart_rxd),
    .uart_rx_en      (uart_rx_en),
    .uart_rx_break   (uart_rx_break),
    .uart_rx_valid   (uart_rx_valid),
    .uart_rx_data    (uart_rx_data),
    .input_gpio_pins (input_gpio_pins),
    .output_gpio_pins(output_gpio_pins),
    .write_done      (write_done),
    .core_rstn       (core_rstn),
    .imem_raddr      (imem_raddr),
    .imem_rdata      (imem_rdata),
    .gpio_in_sync    (gpio_in_sync),
    .gpio_out_req    (gpio_out_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int valid_cnt = 0;
  int break_cnt = 0;
  int wd_cyc = -1;
  int cr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_rx_valid) valid_cnt <= valid_cnt + 1;
    if (uart_rx_break) break_cnt <= break_cnt + 1;
    if (write_done && wd_cyc < 0) wd_cyc <= cyc;
    if (core_rstn && cr_cyc < 0) cr_cyc <= cyc;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Reference loader: what memory should hold given the bytes accepted so far.
  logic [31:0] model_mem [DEPTH];
  logic [7:0]  model_lanes [$];
  int          model_waddr = 0;
  bit          model_done = 1'b0;

  task automatic model_reset();
    model_lanes.delete();
    model_waddr = 0;
    model_done  = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int unsigned w;
    if (model_done) return;
    model_lanes.push_back(b);
    if (model_lanes.size() == 4) begin
      w = int'(model_lanes[0]) + 256 * int'(model_lanes[1])
        + 65536 * int'(model_lanes[2]) + 16777216 * int'(model_lanes[3]);
      if (w == TERM) model_done = 1'b1;
      else if (model_waddr < DEPTH) begin
        model_mem[model_waddr] = w;
        model_waddr++;
      end
      model_lanes.delete();
    end
  endtask

  // A low stop bit is released after 3/4 bit so the line is idle well before any restart check.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit chk);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (chk) check("rx_data_at_stop_start", 32'(uart_rx_data), 32'(b));
    if (stop_ok) begin
      uart_rxd = 1'b1;
      repeat (CPB) @(negedge clk);
      model_byte(b);
    end else begin
      uart_rxd = 1'b0;
      repeat (CPB * 3 / 4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit chk);
    for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1, chk);
  endtask

  task automatic read_check(input int a, input logic [31:0] exp);
    @(negedge clk);
    imem_raddr = AW'(a);
    @(negedge clk);
    check($sformatf("imem[%0d]", a), imem_rdata, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_valid;
    int         exp_break;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [4];
  logic [31:0] prog [10];

  initial begin
    int v0, b0;
    logic [31:0] w;

    vecs[0] = '{8'h13, 1'b1, 1, 0, 8'h13};
    vecs[1] = '{8'h00, 1'b0, 0, 1, 8'h00};
    vecs[2] = '{8'hA5, 1'b0, 0, 0, 8'hA5};
    vecs[3] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

    // Reset state
    repeat (20) @(negedge clk);
    check("rst_rx_valid", 32'(uart_rx_valid), 0);
    check("rst_rx_break", 32'(uart_rx_break), 0);
    check("rst_rx_data", 32'(uart_rx_data), 0);
    check("rst_gpio_out", 32'(output_gpio_pins), 0);
    check("rst_write_done", 32'(write_done), 0);
    check("rst_core_rstn", 32'(core_rstn), 0);
    check("rst_imem_rdata", imem_rdata, 0);
    check("rst_gpio_in_sync", 32'(gpio_in_sync), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("gpio_out_before_done", 32'(output_gpio_pins), 0);

    // Single-frame table
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      b0 = break_cnt;
      send_frame(vecs[i].data, vecs[i].stop_ok, 1'b1);
      check($sformatf("tbl%0d_data", i), 32'(uart_rx_data), 32'(vecs[i].exp_data));
      check($sformatf("tbl%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_break", i), 32'(break_cnt - b0), 32'(vecs[i].exp_break));
    end

    // Start-bit glitch
    v0 = valid_cnt;
    b0 = break_cnt;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    check("glitch_valid", 32'(valid_cnt - v0), 0);
    check("glitch_break", 32'(break_cnt - b0), 0);

    // Receive disable mid-frame
    uart_rxd = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    uart_rx_en = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (CPB * 10) @(negedge clk);
    uart_rx_en = 1'b1;
    repeat (CPB) @(negedge clk);
    check("abort_valid", 32'(valid_cnt - v0), 0);
    check("abort_break", 32'(break_cnt - b0), 0);

    // Reset mid-frame and mid-word (two bytes already in the word)
    uart_rxd = 1'b0;
    repeat (CPB * 2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_rx_data", 32'(uart_rx_data), 0);
    check("midrst_write_done", 32'(write_done), 0);
    model_reset();
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (CPB) @(negedge clk);

    // Program load, overflowing the memory, with a BREAK inside word 5
    prog[0] = 32'h0000_0000;
    prog[1] = 32'h0000_0000;
    prog[2] = 32'hfa01_0113;
    for (int i = 3; i < 10; i++) begin
      w = $urandom;
      if (w == TERM) w = 32'h0;
      prog[i] = w;
    end
    for (int k = 0; k < 10; k++) begin
      w = prog[k];
      if (k == 5) begin
        send_frame(w[7:0], 1'b1, 1'b0);
        send_frame(w[15:8], 1'b1, 1'b0);
        b0 = break_cnt;
        v0 = valid_cnt;
        send_frame(8'h00, 1'b0, 1'b0);
        check("break_in_word_pulse", 32'(break_cnt - b0), 1);
        check("break_in_word_novalid", 32'(valid_cnt - v0), 0);
        send_frame(w[23:16], 1'b1, 1'b0);
        send_frame(w[31:24], 1'b1, 1'b0);
      end else begin
        send_word(w, 1'b0);
      end
      if (k == 2) check("not_done_before_term", 32'(write_done), 0);
    end
    send_word(TERM, 1'b0);
    repeat (4) @(negedge clk);
    check("write_done", 32'(write_done), 1);
    check("core_rstn", 32'(core_rstn), 1);
    check("write_done_seen", 32'(wd_cyc >= 0), 1);
    check("core_rstn_lag", 32'(cr_cyc - wd_cyc), 1);

    for (int a = 0; a < DEPTH; a++) read_check(a, model_mem[a]);
    read_check(1, model_mem[1]);
    read_check(2, 32'hfa01_0113);

    // Bytes after write_done are ignored by the loader
    send_word(32'h0481_2e23, 1'b1);
    check("post_done_rx_data", 32'(uart_rx_data), 32'h04);
    read_check(3, model_mem[3]);
    check("write_done_sticky", 32'(write_done), 1);

    // GPIO
    check("gpio_out_after_done", 32'(output_gpio_pins), 32'b101);
    @(negedge clk);
    gpio_out_req = 3'b010;
    #1;
    check("gpio_out_registered_hold", 32'(output_gpio_pins), 32'b101);
    @(negedge clk);
    check("gpio_out_follow", 32'(output_gpio_pins), 32'b010);
    input_gpio_pins = 2'b00;
    repeat (3) @(negedge clk);
    input_gpio_pins = 2'b10;
    @(negedge clk);
    check("gpio_in_sync_1cyc", 32'(gpio_in_sync), 0);
    @(negedge clk);
    check("gpio_in_sync_2cyc", 32'(gpio_in_sync), 32'b10);

    // Final reset mid-frame, then check loading restarts at address 0
    uart_rxd = 1'b0;
    repeat (CPB + 5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst2_write_done", 32'(write_done), 0);
    check("rst2_core_rstn", 32'(core_rstn), 0);
    check("rst2_gpio_out", 32'(output_gpio_pins), 0);
    check("rst2_rx_data", 32'(uart_rx_data), 0);
    model_reset();
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (CPB) @(negedge clk);
    send_word(32'h1122_3344, 1'b0);
    read_check(0, model_mem[0]);
    read_check(1, model_mem[1]);
    check("rst2_not_done", 32'(write_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
